img_op_sequencer: RTL and testbench
===================================

Name: img_op_sequencer

Overview:
- Op-level controller for the image-processing core.
- Runs the op_ready/op_valid handshake, decodes i_op_mode, holds the display origin and channel depth, and generates image-SRAM write addresses (load) and read addresses (display).
- Hands compute ops (conv, median, sobel) to the compute engine and waits for its completion.
- Sits between the core top-level ports and the 8x8x32 image SRAM and compute engine.

Parameters:
IMG_W, 8, image width and height in pixels (square)
CH_MAX, 32, maximum channel depth
ADDR_W, 11, SRAM address width (log2 of IMG_W*IMG_W*CH_MAX)

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_op_valid  in  1  op command valid; accepted only in WAIT_OP
i_op_mode  in  4  op code, sampled when i_op_valid=1
o_op_ready  out  1  one-cycle pulse: sequencer ready for the next op
i_in_valid  in  1  load pixel valid
o_in_ready  out  1  high throughout LOAD
o_sram_we  out  1  SRAM write enable (= i_in_valid & o_in_ready)
o_sram_addr  out  ADDR_W  SRAM address, write (LOAD) or read (DISP)
o_sram_re  out  1  SRAM read enable during DISP
o_disp_valid  out  1  o_sram_re delayed 1 cycle; aligned with SRAM read data
o_eng_start  out  1  one-cycle engine start pulse
o_eng_mode  out  2  0=conv, 1=median, 2=sobel; held until i_eng_done
o_org_x  out  3  display origin column, 0..6
o_org_y  out  3  display origin row, 0..6
o_depth  out  6  current channel depth: 8, 16 or 32
i_eng_done  in  1  engine completion pulse

Behaviour:
- Reset (async, i_rst_n=0):
  - state=RDY; all pulses/enables=0; o_sram_addr=0.
  - o_org_x=0, o_org_y=0, o_depth=32.
  - Mid-operation reset aborts immediately; no further SRAM writes.
- FSM states: RDY, WAIT_OP, LOAD, UPD, DISP, ENG.
- RDY:
  - o_op_ready=1 for exactly one cycle, then go to WAIT_OP.
  - First o_op_ready is in the first clock edge cycle after reset release.
- WAIT_OP:
  - Hold until i_op_valid=1, then decode i_op_mode.
  - 0000 -> LOAD.
  - 0001..0110 -> UPD.
  - 0111 -> DISP.
  - 1000/1001/1010 -> ENG.
  - 1011..1111 -> RDY directly (no-op, no other side effect).
- LOAD:
  - o_in_ready=1.
  - Address counter starts at 0 and increments on each i_in_valid=1.
  - Address order is channel-major, then row, then column: addr = c*64 + y*8 + x.
  - Gaps in i_in_valid stall the counter.
  - After the write at address 2047 is accepted: o_in_ready falls the next cycle, counter clears, go to RDY.
  - A load always covers all 32 channels, independent of o_depth.
- UPD (1 cycle, then RDY); each update saturates and never wraps:
  - 0001 right shift: org_x+1 if org_x<6, else unchanged.
  - 0010 left shift: org_x-1 if org_x>0, else unchanged.
  - 0011 up shift: org_y-1 if org_y>0, else unchanged.
  - 0100 down shift: org_y+1 if org_y<6, else unchanged.
  - 0101 scale down: depth 32->16->8; 8 stays 8.
  - 0110 scale up: depth 8->16->32; 32 stays 32.
- DISP:
  - Issue depth*4 reads, one per cycle, o_sram_re=1 continuously.
  - Read order: channel c=0..depth-1, then dy=0..1, then dx=0..1.
  - addr = c*64 + (org_y+dy)*8 + (org_x+dx).
  - o_disp_valid follows o_sram_re with 1-cycle delay.
  - Go to RDY in the cycle after the last o_disp_valid; o_op_ready therefore never overlaps o_disp_valid.
- ENG:
  - o_eng_start pulses in the first ENG cycle; o_eng_mode = i_op_mode - 8.
  - Wait for i_eng_done, then go to RDY.
  - i_eng_done arriving in the same cycle as o_eng_start is honoured (ENG lasts 1 cycle).
- Handshake rules:
  - i_op_valid outside WAIT_OP is ignored.
  - i_in_valid outside LOAD is ignored: no write, no counter change.
  - Origin and depth outputs are registered; changes are visible the cycle after UPD.

Test Plan:
- Reset, then op 0000 with 2048 pixels at full rate -> o_sram_we asserted 2048 cycles, addr 0..2047 in order, o_op_ready pulses the cycle after the final write.
- Load with i_in_valid toggling 1,0,1 -> addr advances only on valid cycles; total writes exactly 2048.
- Seven 0001 ops from reset -> org_x goes 1..6 and stays 6. Then 0011 at org_y=0 -> org_y stays 0.
- 0101 three times -> depth 16, 8, 8. Then display at origin (6,6) -> 32 reads: first addresses 54,55,62,63, next 118; 32 o_disp_valid pulses.
- Op 1001 -> o_eng_start one cycle with o_eng_mode=1; i_eng_done 5 cycles later -> o_op_ready pulses the next cycle.
- Op 1100 -> no state change, o_op_ready pulses 1 cycle later. i_rst_n low mid-LOAD at addr 100 -> outputs return to reset values; next load restarts at addr 0.

Source files
------------

// File: rtl/img_op_sequencer_if.sv
// rtl/img_op_sequencer_if.sv - op, load, SRAM and engine signal bundle for img_op_sequencer
//
// Purpose:
//   Groups every non-clock/reset signal of the op sequencer into one bundle.
//   The slave modport is the sequencer's view and the master modport is the
//   surrounding core's view.
//
// Signals (named from the sequencer's point of view):
//   i_op_valid   op command valid
//   i_op_mode    4-bit op code
//   o_op_ready   one-cycle pulse, sequencer ready for the next op
//   i_in_valid   load pixel valid
//   o_in_ready   high throughout a load
//   o_sram_we    SRAM write enable
//   o_sram_addr  SRAM write (load) or read (display) address
//   o_sram_re    SRAM read enable during display
//   o_disp_valid read enable delayed one cycle, aligned with SRAM read data
//   o_eng_start  one-cycle compute engine start pulse
//   o_eng_mode   0=conv, 1=median, 2=sobel
//   o_org_x      display origin column
//   o_org_y      display origin row
//   o_depth      current channel depth (8, 16 or 32)
//   i_eng_done   compute engine completion pulse
interface img_op_sequencer_if #(
   parameter int ADDR_W = 11
);
   logic              i_op_valid;
   logic [3:0]        i_op_mode;
   logic              o_op_ready;
   logic              i_in_valid;
   logic              o_in_ready;
   logic              o_sram_we;
   logic [ADDR_W-1:0] o_sram_addr;
   logic              o_sram_re;
   logic              o_disp_valid;
   logic              o_eng_start;
   logic [1:0]        o_eng_mode;
   logic [2:0]        o_org_x;
   logic [2:0]        o_org_y;
   logic [5:0]        o_depth;
   logic              i_eng_done;

   modport slave (
      input  i_op_valid, i_op_mode, i_in_valid, i_eng_done,
      output o_op_ready, o_in_ready, o_sram_we, o_sram_addr, o_sram_re,
             o_disp_valid, o_eng_start, o_eng_mode, o_org_x, o_org_y, o_depth
   );

   modport master (
      output i_op_valid, i_op_mode, i_in_valid, i_eng_done,
      input  o_op_ready, o_in_ready, o_sram_we, o_sram_addr, o_sram_re,
             o_disp_valid, o_eng_start, o_eng_mode, o_org_x, o_org_y, o_depth
   );
endinterface

// File: rtl/img_op_sequencer.sv
// rtl/img_op_sequencer.sv - op-level controller for the image-processing core
//
// Purpose:
//   Accepts op commands, loads the image SRAM in channel/row/column order,
//   keeps the display origin and channel depth, issues the 2x2-per-channel
//   display reads and hands compute ops to the engine until it reports done.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      img_op_sequencer_if.slave: op handshake, load handshake, SRAM
//            address/enables, display valid, engine start/mode/done,
//            origin and depth outputs
module img_op_sequencer #(
   parameter int IMG_W  = 8,
   parameter int CH_MAX = 32,
   parameter int ADDR_W = 11
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   img_op_sequencer_if.slave bus
);

   localparam int                PIX       = IMG_W * IMG_W;
   localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(PIX * CH_MAX - 1);
   localparam logic [2:0]        ORG_MAX   = 3'(IMG_W - 2);
   localparam logic [5:0]        DEPTH_MIN = 6'd8;
   localparam logic [5:0]        DEPTH_MAX = 6'(CH_MAX);

   typedef enum logic [2:0] {
      RDY,
      WAIT_OP,
      LOAD,
      UPD,
      DISP,
      ENG
   } state_t;

   state_t            state_q, state_d;
   logic              op_ready_q, op_ready_d;
   logic              in_ready_q, in_ready_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              sram_re_q, sram_re_d;
   logic              disp_valid_q, disp_valid_d;
   logic              eng_start_q, eng_start_d;
   logic [1:0]        eng_mode_q, eng_mode_d;
   logic [2:0]        org_x_q, org_x_d;
   logic [2:0]        org_y_q, org_y_d;
   logic [5:0]        depth_q, depth_d;
   logic [3:0]        mode_q, mode_d;
   logic [6:0]        disp_cnt_q, disp_cnt_d;
   logic [6:0]        disp_last;

   // Display read index layout: idx[6:2] = channel, idx[1] = dy, idx[0] = dx.
   function automatic logic [ADDR_W-1:0] disp_addr(
      input logic [6:0] idx,
      input logic [2:0] ox,
      input logic [2:0] oy
   );
      logic [ADDR_W-1:0] c;
      logic [ADDR_W-1:0] y;
      logic [ADDR_W-1:0] x;
      c = ADDR_W'(idx[6:2]);
      y = ADDR_W'(oy) + ADDR_W'(idx[1]);
      x = ADDR_W'(ox) + ADDR_W'(idx[0]);
      return ADDR_W'(c * PIX + y * IMG_W + x);
   endfunction

   // Four reads per channel, so the final index is depth*4 - 1.
   assign disp_last = 7'({depth_q, 2'b00} - 8'd1);

   always_comb begin
      state_d      = state_q;
      op_ready_d   = 1'b0;
      in_ready_d   = in_ready_q;
      addr_d       = addr_q;
      sram_re_d    = sram_re_q;
      disp_valid_d = sram_re_q;
      eng_start_d  = 1'b0;
      eng_mode_d   = eng_mode_q;
      org_x_d      = org_x_q;
      org_y_d      = org_y_q;
      depth_d      = depth_q;
      mode_d       = mode_q;
      disp_cnt_d   = disp_cnt_q;

      case (state_q)
         // Every entry into RDY raises op_ready, so the pulse lands in the
         // RDY cycle itself. Straight out of reset op_ready is still low,
         // so RDY spends one extra cycle raising it.
         RDY: begin
            if (op_ready_q) begin
               state_d = WAIT_OP;
            end else begin
               op_ready_d = 1'b1;
            end
         end

         WAIT_OP: begin
            if (bus.i_op_valid) begin
               mode_d = bus.i_op_mode;
               case (bus.i_op_mode)
                  4'd0: begin
                     state_d    = LOAD;
                     in_ready_d = 1'b1;
                     addr_d     = '0;
                  end
                  4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                     state_d = UPD;
                  end
                  4'd7: begin
                     state_d    = DISP;
                     sram_re_d  = 1'b1;
                     disp_cnt_d = '0;
                     addr_d     = disp_addr(7'd0, org_x_q, org_y_q);
                  end
                  4'd8, 4'd9, 4'd10: begin
                     state_d     = ENG;
                     eng_start_d = 1'b1;
                     // Codes 8..10 map to engine modes 0..2 by their low bits.
                     eng_mode_d  = bus.i_op_mode[1:0];
                  end
                  default: begin
                     state_d    = RDY;
                     op_ready_d = 1'b1;
                  end
               endcase
            end
         end

         LOAD: begin
            if (bus.i_in_valid) begin
               if (addr_q == LOAD_LAST) begin
                  state_d    = RDY;
                  op_ready_d = 1'b1;
                  in_ready_d = 1'b0;
                  addr_d     = '0;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end

         UPD: begin
            case (mode_q)
               4'd1: if (org_x_q < ORG_MAX)   org_x_d = org_x_q + 3'd1;
               4'd2: if (org_x_q != 3'd0)     org_x_d = org_x_q - 3'd1;
               4'd3: if (org_y_q != 3'd0)     org_y_d = org_y_q - 3'd1;
               4'd4: if (org_y_q < ORG_MAX)   org_y_d = org_y_q + 3'd1;
               4'd5: if (depth_q > DEPTH_MIN) depth_d = depth_q >> 1;
               4'd6: if (depth_q < DEPTH_MAX) depth_d = depth_q << 1;
               default: ;
            endcase
            state_d    = RDY;
            op_ready_d = 1'b1;
         end

         // While reads are issued, the next address is prepared each cycle.
         // After the last read one drain cycle carries the final disp_valid,
         // so op_ready can never coincide with display data.
         DISP: begin
            if (sram_re_q) begin
               if (disp_cnt_q == disp_last) begin
                  sram_re_d = 1'b0;
                  addr_d    = '0;
               end else begin
                  disp_cnt_d = disp_cnt_q + 7'd1;
                  addr_d     = disp_addr(disp_cnt_q + 7'd1, org_x_q, org_y_q);
               end
            end else begin
               state_d    = RDY;
               op_ready_d = 1'b1;
            end
         end

         // A done pulse in the same cycle as the start pulse is honoured.
         ENG: begin
            if (bus.i_eng_done) begin
               state_d    = RDY;
               op_ready_d = 1'b1;
            end
         end

         default: begin
            state_d = RDY;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= RDY;
         op_ready_q   <= 1'b0;
         in_ready_q   <= 1'b0;
         addr_q       <= '0;
         sram_re_q    <= 1'b0;
         disp_valid_q <= 1'b0;
         eng_start_q  <= 1'b0;
         eng_mode_q   <= 2'd0;
         org_x_q      <= 3'd0;
         org_y_q      <= 3'd0;
         depth_q      <= DEPTH_MAX;
         mode_q       <= 4'd0;
         disp_cnt_q   <= 7'd0;
      end else begin
         state_q      <= state_d;
         op_ready_q   <= op_ready_d;
         in_ready_q   <= in_ready_d;
         addr_q       <= addr_d;
         sram_re_q    <= sram_re_d;
         disp_valid_q <= disp_valid_d;
         eng_start_q  <= eng_start_d;
         eng_mode_q   <= eng_mode_d;
         org_x_q      <= org_x_d;
         org_y_q      <= org_y_d;
         depth_q      <= depth_d;
         mode_q       <= mode_d;
         disp_cnt_q   <= disp_cnt_d;
      end
   end

   // in_ready is low outside LOAD, so stray pixel valids never write.
   assign bus.o_sram_we    = bus.i_in_valid & in_ready_q;
   assign bus.o_op_ready   = op_ready_q;
   assign bus.o_in_ready   = in_ready_q;
   assign bus.o_sram_addr  = addr_q;
   assign bus.o_sram_re    = sram_re_q;
   assign bus.o_disp_valid = disp_valid_q;
   assign bus.o_eng_start  = eng_start_q;
   assign bus.o_eng_mode   = eng_mode_q;
   assign bus.o_org_x      = org_x_q;
   assign bus.o_org_y      = org_y_q;
   assign bus.o_depth      = depth_q;

endmodule

// File: tb/tb_img_op_sequencer.sv
// tb/tb_img_op_sequencer.sv - scoreboard bench for img_op_sequencer
module tb_img_op_sequencer;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic fin = 1'b0;

   typedef struct {
      int rdy_cyc;
      int ox;
      int oy;
      int depth;
   } exp_st_t;

   exp_st_t exp_st_q[$];
   int      exp_wr_q[$];
   int      exp_rd_q[$];
   int      exp_eng_q[$];

   // Reference model of the programmable state
   int m_ox;
   int m_oy;
   int m_depth;

   img_op_sequencer_if #(.ADDR_W(11)) bus ();

   img_op_sequencer #(.IMG_W(8), .CH_MAX(32), .ADDR_W(11)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor / scoreboard ----------------
   logic prev_re = 1'b0;
   logic prev_es = 1'b0;
   int   idle = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   initial begin
      exp_st_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("reset_outputs",
                int'({bus.o_sram_we, bus.o_in_ready, bus.o_op_ready, bus.o_sram_re,
                      bus.o_disp_valid, bus.o_eng_start, bus.o_org_x, bus.o_org_y,
                      bus.o_depth, bus.o_sram_addr}),
                int'({6'b0, 3'd0, 3'd0, 6'd32, 11'd0}));
            prev_re = 1'b0;
            prev_es = 1'b0;
            idle    = 0;
         end else begin
            if (bus.o_sram_we) begin
               chk("write_expected", int'(exp_wr_q.size() != 0), 1);
               if (exp_wr_q.size() != 0)
                  chk("write_addr", int'(bus.o_sram_addr), exp_wr_q.pop_front());
            end
            if (bus.o_sram_re) begin
               chk("read_expected", int'(exp_rd_q.size() != 0), 1);
               if (exp_rd_q.size() != 0)
                  chk("read_addr", int'(bus.o_sram_addr), exp_rd_q.pop_front());
            end
            if (prev_re || bus.o_disp_valid)
               chk("disp_valid", int'(bus.o_disp_valid), int'(prev_re));
            if (bus.o_disp_valid)
               chk("ready_during_disp", int'(bus.o_op_ready), 0);
            if (bus.o_eng_start) begin
               chk("eng_start_width", int'(prev_es), 0);
               chk("eng_start_expected", int'(exp_eng_q.size() != 0), 1);
               if (exp_eng_q.size() != 0)
                  chk("eng_mode", int'(bus.o_eng_mode), exp_eng_q.pop_front());
            end
            if (bus.o_op_ready) begin
               idle = 0;
               chk("ready_expected", int'(exp_st_q.size() != 0), 1);
               if (exp_st_q.size() != 0) begin
                  e = exp_st_q.pop_front();
                  chk("ready_cycle", cyc, e.rdy_cyc);
                  chk("org_x", int'(bus.o_org_x), e.ox);
                  chk("org_y", int'(bus.o_org_y), e.oy);
                  chk("depth", int'(bus.o_depth), e.depth);
               end
            end else begin
               idle++;
               if (idle == 6000) begin
                  chk("op_ready_watchdog", idle, 0);
                  idle = 0;
               end
            end
            prev_re = bus.o_sram_re;
            prev_es = bus.o_eng_start;
         end
         if (fin) begin
            chk("pending_ready", exp_st_q.size(), 0);
            chk("pending_writes", exp_wr_q.size(), 0);
            chk("pending_reads", exp_rd_q.size(), 0);
            chk("pending_eng", exp_eng_q.size(), 0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_st(input int rc);
      exp_st_t e;
      e.rdy_cyc = rc;
      e.ox      = m_ox;
      e.oy      = m_oy;
      e.depth   = m_depth;
      exp_st_q.push_back(e);
   endtask

   task automatic model_reset();
      m_ox    = 0;
      m_oy    = 0;
      m_depth = 32;
   endtask

   // Returns positioned in the first WAIT_OP cycle after an op_ready pulse.
   task automatic wait_ready();
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.o_op_ready && n < 7000) begin
         @(negedge clk);
         n++;
      end
      tick();
   endtask

   // Presents an op in WAIT_OP; n is the cycle it is accepted in.
   task automatic issue(input logic [3:0] mode, output int n);
      wait_ready();
      repeat ($urandom_range(0, 2)) tick();
      bus.i_op_valid = 1'b1;
      bus.i_op_mode  = mode;
      n = cyc;
      tick();
      bus.i_op_valid = 1'b0;
      bus.i_op_mode  = 4'($urandom);
   endtask

   task automatic do_upd(input logic [3:0] mode);
      int n;
      issue(mode, n);
      case (mode)
         4'd1: if (m_ox < 6) m_ox = m_ox + 1;
         4'd2: if (m_ox > 0) m_ox = m_ox - 1;
         4'd3: if (m_oy > 0) m_oy = m_oy - 1;
         4'd4: if (m_oy < 6) m_oy = m_oy + 1;
         4'd5: if (m_depth > 8) m_depth = m_depth / 2;
         4'd6: if (m_depth < 32) m_depth = m_depth * 2;
         default: ;
      endcase
      push_st(n + 2);
   endtask

   task automatic do_noop(input logic [3:0] mode);
      int n;
      issue(mode, n);
      push_st(n + 1);
   endtask

   task automatic do_disp();
      int n;
      issue(4'd7, n);
      for (int c = 0; c < m_depth; c++)
         for (int dy = 0; dy < 2; dy++)
            for (int dx = 0; dx < 2; dx++)
               exp_rd_q.push_back(c * 64 + (m_oy + dy) * 8 + (m_ox + dx));
      push_st(n + 4 * m_depth + 2);
   endtask

   task automatic do_eng(input logic [3:0] mode, input int d);
      int n;
      issue(mode, n);
      exp_eng_q.push_back(int'(mode) - 8);
      repeat (d) begin
         bus.i_in_valid = 1'($urandom);
         bus.i_op_valid = 1'($urandom);
         tick();
      end
      bus.i_in_valid = 1'b0;
      bus.i_op_valid = 1'b0;
      bus.i_eng_done = 1'b1;
      push_st(cyc + 1);
      tick();
      bus.i_eng_done = 1'b0;
   endtask

   // pat: 0 = full rate, 1 = alternating 1,0,1..., 2 = random gaps
   task automatic do_load(input int pat);
      int   n;
      int   k;
      int   i;
      int   last;
      logic v;
      k    = 0;
      i    = 0;
      last = 0;
      issue(4'd0, n);
      while (k < 2048) begin
         if (pat == 0)      v = 1'b1;
         else if (pat == 1) v = (i % 2 == 0);
         else               v = ($urandom_range(0, 3) != 0);
         bus.i_in_valid = v;
         if (v) begin
            exp_wr_q.push_back(k);
            k++;
            last = cyc;
         end
         tick();
         i++;
      end
      bus.i_in_valid = 1'b0;
      push_st(last + 1);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      bus.i_in_valid = 1'b0;
      rst_n = 1'b1;
      model_reset();
      push_st(cyc + 1);
   endtask

   initial begin
      int n;
      int r;
      rst_n          = 1'b0;
      bus.i_op_valid = 1'b0;
      bus.i_op_mode  = 4'd0;
      bus.i_in_valid = 1'b0;
      bus.i_eng_done = 1'b0;
      model_reset();
      do_reset();

      repeat (7) do_upd(4'd1);
      do_upd(4'd3);
      repeat (3) do_upd(4'd5);
      repeat (6) do_upd(4'd4);
      do_disp();
      do_eng(4'd9, 5);
      do_noop(4'd12);
      do_load(0);
      do_load(1);

      // abort a load once address 100 is presented
      issue(4'd0, n);
      for (int k = 0; k < 100; k++) begin
         bus.i_in_valid = 1'b1;
         exp_wr_q.push_back(k);
         tick();
      end
      bus.i_in_valid = 1'b1;
      do_reset();
      do_load(0);

      do_eng(4'd8, 0);
      do_eng(4'd10, 2);
      do_load(2);

      repeat (80) begin
         r = $urandom_range(0, 9);
         if (r <= 4)      do_upd(4'($urandom_range(1, 6)));
         else if (r == 5) do_noop(4'($urandom_range(11, 15)));
         else if (r <= 7) do_disp();
         else             do_eng(4'($urandom_range(8, 10)), $urandom_range(0, 6));
      end

      for (int i = 0; i < 7000 && exp_st_q.size() != 0; i++) tick();
      repeat (3) tick();
      fin = 1'b1;
      repeat (5) tick();
      $display("FAIL summary_not_reached");
      $fatal(1);
   end

endmodule
